// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key length encodings,
// FSM states, S-box, Rcon and Nk lookups.
package aes_pkg;

    typedef enum logic [1:0] {
        KL_128 = 2'd0,
        KL_192 = 2'd1,
        KL_256 = 2'd2,
        KL_BAD = 2'd3
    } key_len_e;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } state_e;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TAB[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Nk in words; 0 for the illegal encoding.
    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        logic [3:0] n;
        n = 4'd0;
        case (kl)
            KL_128:  n = 4'd4;
            KL_192:  n = 4'd6;
            KL_256:  n = 4'd8;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] nr_of(input logic [3:0] nk);
        return nk + 4'd6;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: forward S-box applied to each byte of a word.
// Ports: i_word (32b in), o_word (32b substituted out).
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {
        sbox(i_word[31:24]),
        sbox(i_word[23:16]),
        sbox(i_word[15:8]),
        sbox(i_word[7:0])
    };

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expander: one word per clock
// into a word store, round keys served combinationally by index.
// Ports: clk, rst (sync high); start/key_len/key request;
// busy/done/err status; key_ready/num_rounds describe the held
// schedule; rk_addr selects, rk_data returns a 128b round key.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         key_ready,
    output logic [3:0]   num_rounds,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);

    logic [31:0]   r_store [DEPTH];
    state_e        r_state;
    state_e        w_state_nxt;
    logic [3:0]    r_nk;
    logic [3:0]    r_nr;
    logic [3:0]    r_wrap;
    logic [3:0]    r_rc_idx;
    logic [AW-1:0] r_i;
    logic [AW-1:0] r_last;
    logic          r_done;
    logic          r_err;
    logic          r_ready;

    logic [3:0]    w_nk_req;
    logic          w_ok;
    logic          w_accept;
    logic          w_reject;
    logic          w_last;
    logic [3:0]    w_nk_gap;
    logic [8:0]    w_shamt;
    logic [255:0]  w_key_al;
    logic [AW-1:0] w_last_req;
    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   w_rot;
    logic [31:0]   w_sub_in;
    logic [31:0]   w_sub_out;
    logic [31:0]   w_temp;
    logic [31:0]   w_new;
    logic          w_rc_step;
    logic          w_sub_only;
    logic [AW-1:0] w_idx;

    assign w_nk_req = nk_of(key_len);
    assign w_ok     = (key_len != KL_BAD)
                   && (int'(w_nk_req) <= MAX_NK);

    // Left-align the active key so w[j] is a fixed slice.
    assign w_nk_gap = 4'd8 - w_nk_req;
    assign w_shamt  = {w_nk_gap, 5'b0};
    assign w_key_al = key << w_shamt;

    // T-1 = 4*Nk + 27
    assign w_last_req = AW'({w_nk_req, 2'b00}) + AW'(27);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_EXPAND;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                if (r_i == r_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Expansion step for w[i].
    assign w_prev = r_store[r_i - AW'(1)];
    assign w_back = r_store[r_i - AW'(r_nk)];
    assign w_rot  = {w_prev[23:0], w_prev[31:24]};

    assign w_rc_step  = (r_wrap == 4'd0);
    assign w_sub_only = (r_nk == 4'd8) && (r_wrap == 4'd4);
    assign w_sub_in   = w_rc_step ? w_rot : w_prev;

    aes_sub_word u_sub (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_temp = w_prev;
        unique case (1'b1)
            w_rc_step:
                w_temp = w_sub_out
                       ^ {rcon(r_rc_idx), 24'h0};
            w_sub_only:
                w_temp = w_sub_out;
            default:
                w_temp = w_prev;
        endcase
    end

    assign w_new = w_back ^ w_temp;

    // Word store carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (j < int'(w_nk_req))
                    r_store[j] <= w_key_al[255-32*j -: 32];
            end
        end else if (r_state == ST_EXPAND) begin
            r_store[r_i] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
            r_nr     <= 4'd0;
            r_nk     <= 4'd0;
            r_i      <= '0;
            r_last   <= '0;
            r_wrap   <= 4'd0;
            r_rc_idx <= 4'd0;
        end else begin
            r_done <= w_last;
            r_err  <= w_reject;
            if (w_accept) begin
                r_ready  <= 1'b0;
                r_nr     <= 4'd0;
                r_nk     <= w_nk_req;
                r_i      <= AW'(w_nk_req);
                r_last   <= w_last_req;
                r_wrap   <= 4'd0;
                r_rc_idx <= 4'd1;
            end else if (r_state == ST_EXPAND) begin
                r_i <= r_i + AW'(1);
                // r_wrap = i mod Nk, r_rc_idx = i / Nk
                if (r_wrap == r_nk - 4'd1) r_wrap <= 4'd0;
                else                       r_wrap <= r_wrap + 4'd1;
                if (w_rc_step) r_rc_idx <= r_rc_idx + 4'd1;
                if (w_last) begin
                    r_ready <= 1'b1;
                    r_nr    <= nr_of(r_nk);
                end
            end
        end
    end

    assign busy       = (r_state == ST_EXPAND);
    assign done       = r_done;
    assign err        = r_err;
    assign key_ready  = r_ready;
    assign num_rounds = r_nr;

    always_comb begin
        rk_data = '0;
        w_idx   = '0;
        if (r_ready && (rk_addr <= r_nr)) begin
            for (int k = 0; k < 4; k++) begin
                w_idx = AW'({rk_addr, 2'b00}) + AW'(k);
                rk_data[127-32*k -: 32] = r_store[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed FIPS-197 vectors for aes_key_schedule, including
// error, reset-abort and back-to-back handshake cases.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic [3:0]   rk_addr;
    logic         busy, done, err, key_ready;
    logic [3:0]   num_rounds;
    logic [127:0] rk_data;

    logic         start2;
    logic [1:0]   key_len2;
    logic         busy2, done2, err2, key_ready2;
    logic [3:0]   num_rounds2;
    logic [127:0] rk_data2;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [255:0] K128 = {
        128'hdeadbeef_01234567_89abcdef_55aa55aa,
        128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [255:0] K192 = {
        64'hffffffff_ffffffff,
        192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d7781_1f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    aes_key_schedule #(.MAX_NK(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_len    (key_len),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .key_ready  (key_ready),
        .num_rounds (num_rounds),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    aes_key_schedule #(.MAX_NK(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .key_len    (key_len2),
        .key        (key),
        .busy       (busy2),
        .done       (done2),
        .err        (err2),
        .key_ready  (key_ready2),
        .num_rounds (num_rounds2),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data2)
    );

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rk_chk(input string tag, input logic [3:0] a,
                          input logic [127:0] exp);
        rk_addr = a;
        @(negedge clk);
        chk(tag, rk_data, exp);
    endtask

    task automatic go(input logic [1:0] kl, input logic [255:0] k,
                      input int lat_exp, input logic [3:0] nr_exp,
                      input string tag);
        int lat;
        key_len = kl;
        key     = k;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk({tag, "_busy"}, 128'(busy), 128'd1);
        chk({tag, "_kr_low"}, 128'(key_ready), 128'd0);
        lat = 1;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'(lat_exp));
        chk({tag, "_kr"}, 128'(key_ready), 128'd1);
        chk({tag, "_nr"}, 128'(num_rounds), 128'(nr_exp));
    endtask

    initial begin
        int lat;
        logic saw;
        rst      = 1'b1;
        start    = 1'b0;
        start2   = 1'b0;
        key_len  = 2'd0;
        key_len2 = 2'd0;
        key      = '0;
        rk_addr  = 4'd0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_kr", 128'(key_ready), 128'd0);
        chk("rst_nr", 128'(num_rounds), 128'd0);
        chk("rst_rk", rk_data, 128'd0);

        // AES-128, then a start in the done cycle.
        go(2'd0, K128, 41, 4'd10, "a128");
        go(2'd0, K128, 41, 4'd10, "b2b");
        rk_chk("a128_rk0", 4'd0,
               128'h2b7e151628aed2a6abf7158809cf4f3c);
        rk_chk("a128_rk1", 4'd1,
               128'ha0fafe1788542cb123a339392a6c7605);
        rk_chk("a128_rk10", 4'd10,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rk_chk("a128_rk11", 4'd11, 128'd0);

        // AES-192
        go(2'd1, K192, 47, 4'd12, "a192");
        rk_chk("a192_rk0", 4'd0,
               128'h8e73b0f7da0e6452c810f32b809079e5);
        rk_chk("a192_rk1", 4'd1,
               128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        rk_chk("a192_rk12", 4'd12,
               128'he98ba06f448c773c8ecc720401002202);
        rk_chk("a192_rk13", 4'd13, 128'd0);

        // Illegal key length
        tick();
        key_len = 2'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("bad_err", 128'(err), 128'd1);
        chk("bad_busy", 128'(busy), 128'd0);
        chk("bad_kr", 128'(key_ready), 128'd1);
        chk("bad_nr", 128'(num_rounds), 128'd12);
        tick();
        chk("bad_err_pulse", 128'(err), 128'd0);
        rk_chk("bad_rk12", 4'd12,
               128'he98ba06f448c773c8ecc720401002202);

        // MAX_NK=4 instance rejects AES-256
        key      = K128;
        key_len2 = 2'd0;
        start2   = 1'b1;
        tick();
        start2   = 1'b0;
        lat = 1;
        while (!done2 && lat < 200) begin
            tick();
            lat++;
        end
        chk("n4_lat", 128'(lat), 128'd41);
        key_len2 = 2'd2;
        start2   = 1'b1;
        tick();
        start2   = 1'b0;
        chk("n4_err", 128'(err2), 128'd1);
        chk("n4_busy", 128'(busy2), 128'd0);
        chk("n4_kr", 128'(key_ready2), 128'd1);
        chk("n4_nr", 128'(num_rounds2), 128'd10);
        rk_addr = 4'd10;
        @(negedge clk);
        chk("n4_rk10", rk_data2,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-256 with stray start pulses while busy
        tick();
        key_len = 2'd2;
        key     = K256;
        start   = 1'b1;
        tick();
        key_len = 2'd0;
        start   = 1'b0;
        saw     = 1'b0;
        lat     = 1;
        while (!done && lat < 200) begin
            start = (lat == 5) || (lat == 20) || (lat == 40);
            tick();
            lat++;
            saw = saw | err;
        end
        start = 1'b0;
        chk("a256_lat", 128'(lat), 128'd53);
        chk("a256_noerr", 128'(saw), 128'd0);
        chk("a256_nr", 128'(num_rounds), 128'd14);
        rk_chk("a256_rk1", 4'd1,
               128'h1f352c073b6108d72d9810a30914dff4);
        rk_chk("a256_rk2", 4'd2,
               128'h9ba354118e6925afa51a8b5f2067fcde);
        rk_chk("a256_rk14", 4'd14,
               128'hfe4890d1e6188d0b046df344706c631e);
        rk_chk("a256_rk15", 4'd15, 128'd0);

        // Reset in the middle of an AES-128 run
        tick();
        key_len = 2'd0;
        key     = K128;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy", 128'(busy), 128'd0);
        chk("mid_done", 128'(done), 128'd0);
        chk("mid_err", 128'(err), 128'd0);
        chk("mid_kr", 128'(key_ready), 128'd0);
        chk("mid_nr", 128'(num_rounds), 128'd0);
        chk("mid_rk", rk_data, 128'd0);
        go(2'd2, K256, 53, 4'd14, "rerun");
        rk_chk("rerun_rk14", 4'd14,
               128'hfe4890d1e6188d0b046df344706c631e);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
